// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared arbiter state type and default text RAM geometry
package vga_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_DISP = 2'd1,
        GNT_HOST = 2'd2
    } arb_state_t;

    localparam int TEXT_AW = 10;
    localparam int TEXT_DW = 8;
endpackage

// File: rtl/arb_wait_guard.sv
// rtl/arb_wait_guard.sv - counts host losses to display and forces a host win at MAX_WAIT
module arb_wait_guard #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic host_req,
    input  logic host_elig,
    input  logic disp_win,
    input  logic host_gnt,
    output logic force_host
);
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!host_req || host_gnt) begin
            wait_cnt_d = 8'd0;
        end else if (host_elig && disp_win && (wait_cnt_q != MAX_W)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Depends only on the register, so the arbitration path has no loop.
    assign force_host = (wait_cnt_q == MAX_W);
endmodule

// File: rtl/text_ram_arb.sv
// rtl/text_ram_arb.sv - display/host arbiter for a single-port text RAM
// Optional TEXT_RAM_ARB_STATS_EN adds conflict_cnt and forced_cnt outputs.
module text_ram_arb
    import vga_pkg::*;
#(
    parameter int AW       = TEXT_AW,
    parameter int DW       = TEXT_DW,
    parameter int MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_ack,
    output logic          disp_vld,
    output logic [DW-1:0] disp_data,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic          host_rvld,
    output logic [DW-1:0] host_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
`ifdef TEXT_RAM_ARB_STATS_EN
    ,
    output logic [15:0]   conflict_cnt,
    output logic [7:0]    forced_cnt
`endif
);
    arb_state_t    state_q, state_d;
    logic          disp_elig, host_elig, force_host;
    logic          disp_ack_q, host_ack_q, disp_vld_q, host_rvld_q;
    logic          ram_en_q, ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;

    // A requester's inputs are stale during its own ack cycle.
    assign disp_elig = disp_req && (state_q != GNT_DISP);
    assign host_elig = host_req && (state_q != GNT_HOST);

    always_comb begin
        state_d = IDLE;
        if (disp_elig && host_elig && force_host) begin
            state_d = GNT_HOST;
        end else if (disp_elig) begin
            state_d = GNT_DISP;
        end else if (host_elig) begin
            state_d = GNT_HOST;
        end
    end

    arb_wait_guard #(.MAX_WAIT(MAX_WAIT)) u_guard (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_req   (host_req),
        .host_elig  (host_elig),
        .disp_win   (state_d == GNT_DISP),
        .host_gnt   (state_d == GNT_HOST),
        .force_host (force_host)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            disp_ack_q  <= 1'b0;
            host_ack_q  <= 1'b0;
            disp_vld_q  <= 1'b0;
            host_rvld_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            disp_ack_q  <= (state_d == GNT_DISP);
            host_ack_q  <= (state_d == GNT_HOST);
            ram_en_q    <= (state_d != IDLE);
            disp_vld_q  <= (state_q == GNT_DISP);
            host_rvld_q <= (state_q == GNT_HOST) && !ram_we_q;
            case (state_d)
                GNT_DISP: begin
                    ram_we_q   <= 1'b0;
                    ram_addr_q <= disp_addr;
                end
                GNT_HOST: begin
                    ram_we_q    <= host_we;
                    ram_addr_q  <= host_addr;
                    ram_wdata_q <= host_wdata;
                end
                default: ram_we_q <= 1'b0;
            endcase
        end
    end

    assign disp_ack   = disp_ack_q;
    assign host_ack   = host_ack_q;
    assign disp_vld   = disp_vld_q;
    assign host_rvld  = host_rvld_q;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    // Gated so the data outputs also read 0 while in reset.
    assign disp_data  = disp_vld_q  ? ram_rdata : '0;
    assign host_rdata = host_rvld_q ? ram_rdata : '0;

`ifdef TEXT_RAM_ARB_STATS_EN
    logic [15:0] conflict_cnt_q;
    logic [7:0]  forced_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= 16'd0;
            forced_cnt_q   <= 8'd0;
        end else begin
            if (disp_elig && host_elig && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
            if (disp_elig && host_elig && force_host && (forced_cnt_q != 8'hFF)) begin
                forced_cnt_q <= forced_cnt_q + 8'd1;
            end
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign forced_cnt   = forced_cnt_q;
`endif
endmodule

// File: tb/tb_text_ram_arb.sv
// tb/tb_text_ram_arb.sv - scoreboard bench for text_ram_arb with a reference RAM and arbiter model
module tb_text_ram_arb;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic [DW-1:0] ram_rdata = '0;
    logic          disp_ack, disp_vld, host_ack, host_rvld, ram_en, ram_we;
    logic [DW-1:0] disp_data, host_rdata, ram_wdata;
    logic [AW-1:0] ram_addr;
`ifdef TEXT_RAM_ARB_STATS_EN
    logic [15:0]   conflict_cnt;
    logic [7:0]    forced_cnt;
`endif

    always #10 clk = ~clk;

    text_ram_arb #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_vld(disp_vld), .disp_data(disp_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rvld(host_rvld),
        .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef TEXT_RAM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt), .forced_cnt(forced_cnt)
`endif
    );

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int            g;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_t;

    gnt_t          gq[$];
    logic [DW-1:0] dq[$];
    logic [DW-1:0] hq[$];
    int m_last = 0, m_wcnt = 0, m_conf = 0, m_forced = 0;

    // Reference: who gets the RAM on each edge, and what each read must return.
    always @(posedge clk) begin : model_p
        gnt_t e;
        bit   de, he;
        int   g;
        if (!rst_n) begin
            m_last = 0; m_wcnt = 0; m_conf = 0; m_forced = 0;
            gq.delete(); dq.delete(); hq.delete();
        end else begin
            de = disp_req && (m_last != 1);
            he = host_req && (m_last != 2);
            if (de && he && m_wcnt == MW) g = 2;
            else if (de)                  g = 1;
            else if (he)                  g = 2;
            else                          g = 0;
            if (de && he && m_conf < 65535) m_conf++;
            if (de && he && m_wcnt == MW && m_forced < 255) m_forced++;
            if (!host_req || g == 2) m_wcnt = 0;
            else if (he && g == 1 && m_wcnt < MW) m_wcnt++;
            e.g = g; e.we = 1'b0; e.addr = '0; e.wdata = '0;
            if (g == 1) begin
                e.addr = disp_addr;
                dq.push_back(ref_mem[disp_addr]);
            end else if (g == 2) begin
                e.we = host_we; e.addr = host_addr; e.wdata = host_wdata;
                if (host_we) ref_mem[host_addr] = host_wdata;
                else         hq.push_back(ref_mem[host_addr]);
            end
            gq.push_back(e);
            m_last = g;
        end
    end

    always @(negedge clk) begin : monitor_p
        gnt_t e;
        if (rst_n) begin
            if (gq.size() > 0) begin
                e = gq.pop_front();
                check("disp_ack", 32'(disp_ack), 32'(e.g == 1));
                check("host_ack", 32'(host_ack), 32'(e.g == 2));
                check("ram_en", 32'(ram_en), 32'(e.g != 0));
                check("ram_we", 32'(ram_we), 32'(e.g == 2 && e.we));
                if (e.g != 0) check("ram_addr", 32'(ram_addr), 32'(e.addr));
                if (e.g == 2 && e.we) check("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
            end
            if (disp_vld) begin
                if (dq.size() == 0) check("disp_vld_unexpected", 32'(1), 32'(0));
                else check("disp_data", 32'(disp_data), 32'(dq.pop_front()));
            end
            if (host_rvld) begin
                if (hq.size() == 0) check("host_rvld_unexpected", 32'(1), 32'(0));
                else check("host_rdata", 32'(host_rdata), 32'(hq.pop_front()));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_acks_vlds"}, 32'({disp_ack, host_ack, disp_vld, host_rvld}), 32'(0));
        check({tag, "_ram_ctl"}, 32'({ram_en, ram_we}), 32'(0));
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'(0));
        check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'(0));
        check({tag, "_data"}, 32'({disp_data, host_rdata}), 32'(0));
    endtask

    task automatic host_op(input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
        int n;
        @(negedge clk);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!host_ack && n < 20);
        check("host_op_ack_seen", 32'(host_ack), 32'(1));
        check("host_op_ram_we", 32'(ram_we), 32'(we));
        check("host_op_ram_addr", 32'(ram_addr), 32'(a));
        host_req = 1'b0;
        @(negedge clk);
        check("host_op_rvld", 32'(host_rvld), 32'(!we));
        if (!we) check("host_op_rdata", 32'(host_rdata), 32'(exp_rd));
    endtask

    initial begin
        int n;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end
        mem[5] = 8'hA5; ref_mem[5] = 8'hA5;

        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Display-only read of preloaded location.
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 10'h005;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!disp_ack && n < 20);
        check("disp_ack_latency", 32'(n), 32'(1));
        check("disp_only_ram", 32'({ram_en, ram_we}), 32'(2'b10));
        check("disp_only_addr", 32'(ram_addr), 32'(10'h005));
        disp_req = 1'b0;
        @(negedge clk);
        check("disp_only_vld", 32'(disp_vld), 32'(1));
        check("disp_only_data", 32'(disp_data), 32'(8'hA5));

        host_op(1'b1, 10'h1FF, 8'h3C, 8'h00);
        host_op(1'b0, 10'h1FF, 8'h00, 8'h3C);

        // Simultaneous requests: display first, host on the next edge.
        @(negedge clk);
        disp_req = 1'b1; disp_addr = 10'h007;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h009;
        @(negedge clk);
        check("simul_first", 32'({disp_ack, host_ack}), 32'(2'b10));
        disp_req = 1'b0;
        @(negedge clk);
        check("simul_second", 32'({disp_ack, host_ack}), 32'(2'b01));
        host_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a host write grant.
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'h3FF; host_wdata = 8'h77;
        @(negedge clk);
        check("midgrant_ack", 32'({host_ack, ram_we}), 32'(2'b11));
        #2 rst_n = 1'b0;
        host_req = 1'b0; host_we = 1'b0;
        #1 check_all_zero("midgrant_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_quiet", 32'({disp_ack, host_ack, disp_vld, host_rvld}), 32'(0));

        // Randomized traffic on a small address window.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (disp_req) begin
                if (disp_ack || $urandom_range(0, 15) == 0) begin
                    disp_req  = 1'($urandom_range(0, 3) != 0);
                    disp_addr = AW'($urandom_range(0, 31));
                end
            end else if ($urandom_range(0, 2) == 0) begin
                disp_req  = 1'b1;
                disp_addr = AW'($urandom_range(0, 31));
            end
            if (host_req) begin
                if (host_ack || $urandom_range(0, 15) == 0) begin
                    host_req   = 1'($urandom_range(0, 1));
                    host_we    = 1'($urandom_range(0, 1));
                    host_addr  = AW'($urandom_range(0, 31));
                    host_wdata = DW'($urandom);
                end
            end else if ($urandom_range(0, 2) == 0) begin
                host_req   = 1'b1;
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = AW'($urandom_range(0, 31));
                host_wdata = DW'($urandom);
            end
        end

        disp_req = 1'b0; host_req = 1'b0;
        repeat (6) @(negedge clk);
        check("drain_grant_q", 32'(gq.size() > 2), 32'(0));
        check("drain_disp_q", 32'(dq.size()), 32'(0));
        check("drain_host_q", 32'(hq.size()), 32'(0));
`ifdef TEXT_RAM_ARB_STATS_EN
        check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
        check("forced_cnt", 32'(forced_cnt), 32'(m_forced));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
